effect_scheduler: RTL and testbench

//  Frame-level controller for the shared effect engine. Each rising LRCK edge, it captures one

---
 rtl/effect_scheduler_pkg.sv | 22 ++
 rtl/effect_scheduler_sw_debounce.sv | 39 +++
 rtl/effect_scheduler.sv | 239 +++++++++++++++++++++++
 tb/tb_effect_scheduler.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/effect_scheduler_pkg.sv
// Shared types and constants for the effect scheduler.
//   state_t : frame controller states (IDLE, REQ_L, RSP_L, REQ_R, RSP_R)
//   CH_L/CH_R : engine channel tags (0 = left, 1 = right)
//   chan_of : channel handled by a given state
package effect_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ_L = 3'd1,
    RSP_L = 3'd2,
    REQ_R = 3'd3,
    RSP_R = 3'd4
  } state_t;

  localparam logic CH_L = 1'b0;
  localparam logic CH_R = 1'b1;

  function automatic logic chan_of(input state_t s);
    return ((s == REQ_R) || (s == RSP_R)) ? CH_R : CH_L;
  endfunction

endpackage

// File: rtl/effect_scheduler_sw_debounce.sv
// Single-bit stability filter for an already synchronised switch input.
// The output follows the input only after the input has held a value
// different from the current output for DB_CYC consecutive clocks.
// Ports:
//   i_clk   clock
//   i_rst_n asynchronous active-low reset (output resets to 0)
//   i_bit   synchronised raw switch bit
//   o_bit   debounced switch bit
module effect_scheduler_sw_debounce #(
  parameter int unsigned DB_CYC = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_bit,
  output logic o_bit
);

  localparam int unsigned CW = $clog2(DB_CYC + 1);

  logic [CW-1:0] r_cnt;
  logic          r_stable;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else if (i_bit == r_stable) begin
      r_cnt <= '0;
    end else if (r_cnt == CW'(DB_CYC - 1)) begin
      r_stable <= i_bit;
      r_cnt    <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_bit = r_stable;

endmodule

// File: rtl/effect_scheduler.sv
// Frame-level controller for the shared effect engine. On each rising edge
// of the synchronised LRCK it captures one stereo frame plus the switch
// configuration, sends L then R through the engine with a valid/ready
// handshake, and presents both results together with a one-cycle
// frame_done pulse. An engine that stays silent for TIMEOUT cycles is
// bypassed with the dry sample.
// Build option: define SW_DEBOUNCE_EN to add a DB_CYC stability filter on
// every switch bit after its 2-flop synchroniser.
// Ports:
//   clk, reset_n              MCLK and asynchronous active-low reset
//   lrck                      LR clock (asynchronous, synchronised here)
//   data_l_in, data_r_in      decoded samples
//   sw_in                     raw effect-enable switches
//   eng_valid/ready/data/chan/cfg   request side of the engine
//   res_valid, res_data       result side of the engine
//   data_l_out, data_r_out    processed samples, held between frames
//   frame_done                pulse when the outputs update
//   busy                      controller not idle
//   overrun, timeout_err      sticky error flags, cleared by err_clr
module effect_scheduler
  import effect_scheduler_pkg::*;
#(
  parameter int unsigned RES     = 32,
  parameter int unsigned NCFG    = 10,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned DB_CYC  = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            lrck,
  input  logic [RES-1:0]  data_l_in,
  input  logic [RES-1:0]  data_r_in,
  input  logic [NCFG-1:0] sw_in,
  output logic            eng_valid,
  input  logic            eng_ready,
  output logic [RES-1:0]  eng_data,
  output logic            eng_chan,
  output logic [NCFG-1:0] eng_cfg,
  input  logic            res_valid,
  input  logic [RES-1:0]  res_data,
  output logic [RES-1:0]  data_l_out,
  output logic [RES-1:0]  data_r_out,
  output logic            frame_done,
  output logic            busy,
  output logic            overrun,
  output logic            timeout_err,
  input  logic            err_clr
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  // LRCK synchroniser and rising-edge detect
  logic r_lrck_s1, r_lrck_s2, r_lrck_d;
  logic w_frame_edge;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lrck_s1 <= 1'b0;
      r_lrck_s2 <= 1'b0;
      r_lrck_d  <= 1'b0;
    end else begin
      r_lrck_s1 <= lrck;
      r_lrck_s2 <= r_lrck_s1;
      r_lrck_d  <= r_lrck_s2;
    end
  end

  assign w_frame_edge = r_lrck_s2 & ~r_lrck_d;

  // Switch synchroniser, optionally followed by a debounce filter
  logic [NCFG-1:0] r_sw_s1, r_sw_s2;
  logic [NCFG-1:0] w_sw;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sw_s1 <= '0;
      r_sw_s2 <= '0;
    end else begin
      r_sw_s1 <= sw_in;
      r_sw_s2 <= r_sw_s1;
    end
  end

`ifdef SW_DEBOUNCE_EN
  for (genvar gi = 0; gi < NCFG; gi++) begin : g_db
    effect_scheduler_sw_debounce #(
      .DB_CYC (DB_CYC)
    ) u_db (
      .i_clk   (clk),
      .i_rst_n (reset_n),
      .i_bit   (r_sw_s2[gi]),
      .o_bit   (w_sw[gi])
    );
  end
`else
  assign w_sw = r_sw_s2;
  // DB_CYC has no effect without the debounce filter.
  if (DB_CYC > 0) begin : g_db_unused
  end
`endif

  // Frame controller
  state_t          r_state, w_state_nxt;
  logic [RES-1:0]  r_cap_l, r_cap_r, r_res_l;
  logic [RES-1:0]  r_out_l, r_out_r;
  logic [NCFG-1:0] r_cfg;
  logic [TW-1:0]   r_tcnt;
  logic            r_done, r_ovr, r_terr;

  logic w_capture, w_take_l, w_finish, w_tmo, w_tmo_hit, w_tcnt_clr;

  assign w_tmo = (r_tcnt == TW'(TIMEOUT - 1));

  // A timeout in REQ_* or RSP_* stands in for the missing result; a
  // handshake or a real result on the same cycle takes precedence.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_take_l    = 1'b0;
    w_finish    = 1'b0;
    w_tmo_hit   = 1'b0;
    w_tcnt_clr  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_frame_edge) begin
          w_capture   = 1'b1;
          w_tcnt_clr  = 1'b1;
          w_state_nxt = REQ_L;
        end
      end
      REQ_L: begin
        if (eng_ready) begin
          w_state_nxt = RSP_L;
        end else if (w_tmo) begin
          w_tmo_hit   = 1'b1;
          w_take_l    = 1'b1;
          w_tcnt_clr  = 1'b1;
          w_state_nxt = REQ_R;
        end
      end
      RSP_L: begin
        if (res_valid || w_tmo) begin
          w_tmo_hit   = ~res_valid;
          w_take_l    = 1'b1;
          w_tcnt_clr  = 1'b1;
          w_state_nxt = REQ_R;
        end
      end
      REQ_R: begin
        if (eng_ready) begin
          w_state_nxt = RSP_R;
        end else if (w_tmo) begin
          w_tmo_hit   = 1'b1;
          w_finish    = 1'b1;
          w_tcnt_clr  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      RSP_R: begin
        if (res_valid || w_tmo) begin
          w_tmo_hit   = ~res_valid;
          w_finish    = 1'b1;
          w_tcnt_clr  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tcnt <= '0;
    end else if (w_tcnt_clr) begin
      r_tcnt <= '0;
    end else if (r_state != IDLE) begin
      r_tcnt <= r_tcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cap_l <= '0;
      r_cap_r <= '0;
      r_cfg   <= '0;
      r_res_l <= '0;
      r_out_l <= '0;
      r_out_r <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_capture) begin
        r_cap_l <= data_l_in;
        r_cap_r <= data_r_in;
        r_cfg   <= w_sw;
      end
      if (w_take_l) begin
        r_res_l <= w_tmo_hit ? r_cap_l : res_data;
      end
      if (w_finish) begin
        r_out_l <= r_res_l;
        r_out_r <= w_tmo_hit ? r_cap_r : res_data;
      end
    end
  end

  // Sticky flags: a new set event wins over err_clr on the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ovr  <= 1'b0;
      r_terr <= 1'b0;
    end else begin
      if (w_frame_edge && (r_state != IDLE)) r_ovr <= 1'b1;
      else if (err_clr)                      r_ovr <= 1'b0;
      if (w_tmo_hit)                         r_terr <= 1'b1;
      else if (err_clr)                      r_terr <= 1'b0;
    end
  end

  assign eng_valid   = (r_state == REQ_L) || (r_state == REQ_R);
  assign eng_chan    = chan_of(r_state);
  assign eng_data    = (chan_of(r_state) == CH_R) ? r_cap_r : r_cap_l;
  assign eng_cfg     = r_cfg;
  assign busy        = (r_state != IDLE);
  assign data_l_out  = r_out_l;
  assign data_r_out  = r_out_r;
  assign frame_done  = r_done;
  assign overrun     = r_ovr;
  assign timeout_err = r_terr;

endmodule

// File: tb/tb_effect_scheduler.sv
// Self-checking bench for effect_scheduler: engine model with configurable
// ready delay / latency / silence, a frame-level reference (expected
// requests and expected output pairs) and a per-cycle compare process.
module tb_effect_scheduler;

  localparam int unsigned RES     = 32;
  localparam int unsigned NCFG    = 10;
  localparam int unsigned TIMEOUT = 64;
  localparam int unsigned DB_CYC  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset_n, lrck, err_clr;
  logic [RES-1:0]  data_l_in, data_r_in;
  logic [NCFG-1:0] sw_in;
  logic            eng_valid, eng_ready, eng_chan;
  logic [RES-1:0]  eng_data, res_data;
  logic [NCFG-1:0] eng_cfg;
  logic            res_valid;
  logic [RES-1:0]  data_l_out, data_r_out;
  logic            frame_done, busy, overrun, timeout_err;

  effect_scheduler #(
    .RES(RES), .NCFG(NCFG), .TIMEOUT(TIMEOUT), .DB_CYC(DB_CYC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .lrck(lrck),
    .data_l_in(data_l_in), .data_r_in(data_r_in), .sw_in(sw_in),
    .eng_valid(eng_valid), .eng_ready(eng_ready), .eng_data(eng_data),
    .eng_chan(eng_chan), .eng_cfg(eng_cfg),
    .res_valid(res_valid), .res_data(res_data),
    .data_l_out(data_l_out), .data_r_out(data_r_out),
    .frame_done(frame_done), .busy(busy), .overrun(overrun),
    .timeout_err(timeout_err), .err_clr(err_clr)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference model: what the engine must be asked, and what the frame must produce
  typedef struct { logic [RES-1:0] d; logic ch; logic [NCFG-1:0] cfg; } req_t;
  typedef struct { logic [RES-1:0] l; logic [RES-1:0] r; } frm_t;
  typedef struct { int due; logic [RES-1:0] d; } rsp_t;

  req_t req_q[$];
  frm_t frm_q[$];
  logic [RES-1:0] exp_l = '0, exp_r = '0;
  int hs_cyc[2];
  int vrise[2];
  int cyc_n = 0;
  int done_cnt = 0;

  // Engine behaviour knobs
  int unsigned ready_delay = 0;
  int unsigned lat = 3;
  bit mute = 1'b0;

  // Engine model: decides ready and result strobes half a cycle before each edge
  initial begin : engine
    rsp_t pq[$];
    rsp_t p;
    int ncyc;
    int unsigned wcnt;
    eng_ready = 1'b0; res_valid = 1'b0; res_data = '0; ncyc = 0; wcnt = 0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (!reset_n) begin
        pq.delete();
        eng_ready = 1'b0; res_valid = 1'b0; wcnt = 0;
      end else begin
        if (eng_valid) begin
          if (wcnt < ready_delay) begin eng_ready = 1'b0; wcnt++; end
          else eng_ready = 1'b1;
        end else begin
          eng_ready = 1'b0; wcnt = 0;
        end
        if (eng_valid && eng_ready && !mute) begin
          p.due = ncyc + int'(lat);
          p.d   = eng_data + 1;
          pq.push_back(p);
        end
        res_valid = 1'b0;
        if (pq.size() > 0 && pq[0].due <= ncyc) begin
          p = pq.pop_front();
          res_valid = 1'b1;
          res_data  = p.d;
        end
      end
    end
  end

  // Compare process: handshake stability, request contents, output pairs
  initial begin : compare
    logic pend, pc, pv;
    logic [RES-1:0] pd;
    req_t e;
    frm_t f;
    pend = 1'b0; pv = 1'b0; pc = 1'b0; pd = '0;
    forever begin
      @(negedge clk);
      #2;
      cyc_n++;
      if (!reset_n) begin
        pend = 1'b0; pv = 1'b0;
      end else begin
        if (pend) begin
          chk("hold_valid", eng_valid, 1);
          chk("hold_data", eng_data, pd);
          chk("hold_chan", eng_chan, pc);
        end
        if (eng_valid && !pv) vrise[eng_chan] = cyc_n;
        pv = eng_valid;
        pend = eng_valid && !eng_ready;
        pd = eng_data; pc = eng_chan;
        if (eng_valid && eng_ready) begin
          hs_cyc[eng_chan] = cyc_n;
          if (req_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_req: got chan %0d data 0x%0h, expected no request", eng_chan, eng_data);
          end else begin
            e = req_q.pop_front();
            chk("req_data", eng_data, e.d);
            chk("req_chan", eng_chan, e.ch);
            chk("req_cfg", eng_cfg, e.cfg);
          end
        end
        if (frame_done) begin
          done_cnt++;
          if (frm_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL spurious_done: got frame_done 1 expected 0");
          end else begin
            f = frm_q.pop_front();
            exp_l = f.l; exp_r = f.r;
          end
        end
        chk("data_l_out", data_l_out, exp_l);
        chk("data_r_out", data_r_out, exp_r);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_sw(input logic [NCFG-1:0] v);
    tick(1);
    sw_in = v;
    tick(DB_CYC + 8);
  endtask

  // Present a frame and raise lrck; when accepted, record the expected traffic
  task automatic launch(input logic [RES-1:0] l, input logic [RES-1:0] r,
                        input logic [NCFG-1:0] cfg, input bit accepted);
    req_t q;
    frm_t f;
    tick(1);
    data_l_in = l; data_r_in = r; lrck = 1'b1;
    if (accepted) begin
      q.d = l; q.ch = 1'b0; q.cfg = cfg; req_q.push_back(q);
      q.d = r; q.ch = 1'b1; req_q.push_back(q);
      f.l = mute ? l : l + 1;
      f.r = mute ? r : r + 1;
      frm_q.push_back(f);
    end
    tick(6);
    lrck = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int n = 0;
    while ((frm_q.size() != 0 || busy) && n < budget) begin tick(1); n++; end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL %s: got no completion in %0d cycles, expected frame_done", nm, budget);
    end
  endtask

  task automatic wait_req(input string nm, input int left, input int budget);
    int n = 0;
    while (req_q.size() > left && n < budget) begin tick(1); n++; end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL %s: got %0d pending requests, expected %0d", nm, req_q.size(), left);
    end
  endtask

  task automatic pulse_clr();
    tick(1); err_clr = 1'b1;
    tick(1); err_clr = 1'b0;
    tick(1);
  endtask

  initial begin : stim
    int d0;
    logic [NCFG-1:0] sv;
    reset_n = 1'b0; lrck = 1'b0; err_clr = 1'b0;
    data_l_in = '0; data_r_in = '0; sw_in = '0;
    tick(3);
    chk("rst_eng_valid", eng_valid, 0);
    chk("rst_eng_data", eng_data, 0);
    chk("rst_eng_cfg", eng_cfg, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_out_l", data_l_out, 0);
    chk("rst_flags", {overrun, timeout_err}, 0);
    reset_n = 1'b1;

    // 1: basic frame, ready=1, latency 3
    set_sw(10'h001);
    launch(32'h10, 32'h20, 10'h001, 1'b1);
    wait_done("t1_done", 200);
    chk("t1_out_l", data_l_out, 32'h11);
    chk("t1_out_r", data_r_out, 32'h21);
    chk("t1_l_to_r_cycles", hs_cyc[1] - hs_cyc[0], 4);
    chk("t1_done_cnt", done_cnt, 1);

    // 2: ready held low for 5 cycles in REQ_L
    ready_delay = 5;
    launch(32'hAAAA0001, 32'h55550002, 10'h001, 1'b1);
    wait_done("t2_done", 200);
    chk("t2_ready_wait", hs_cyc[0] - vrise[0], 5);
    chk("t2_out_l", data_l_out, 32'hAAAA0002);
    chk("t2_terr", timeout_err, 0);
    ready_delay = 0;

    // 3: silent engine -> dry samples after TIMEOUT cycles per channel
    mute = 1'b1;
    launch(32'h1234, 32'h5678, 10'h001, 1'b1);
    wait_done("t3_done", 400);
    chk("t3_out_l", data_l_out, 32'h1234);
    chk("t3_out_r", data_r_out, 32'h5678);
    chk("t3_timeout_cycles", hs_cyc[1] - hs_cyc[0], TIMEOUT);
    chk("t3_terr_set", timeout_err, 1);
    pulse_clr();
    chk("t3_terr_clr", timeout_err, 0);
    mute = 1'b0;

    // 4: second edge while in RSP_R -> overrun, frame dropped
    chk("t4_ovr_pre", overrun, 0);
    lat = 20;
    d0 = done_cnt;
    launch(32'h100, 32'h200, 10'h001, 1'b1);
    wait_req("t4_r_req", 0, 100);
    launch(32'hDEAD, 32'hBEEF, 10'h001, 1'b0);
    wait_done("t4_done", 200);
    tick(30);
    chk("t4_ovr_set", overrun, 1);
    chk("t4_out_l", data_l_out, 32'h101);
    chk("t4_out_r", data_r_out, 32'h201);
    chk("t4_done_cnt", done_cnt - d0, 1);
    chk("t4_idle", busy, 0);
    pulse_clr();
    chk("t4_ovr_clr", overrun, 0);

    // 5: switches change mid-frame; config holds until next capture
    lat = 10;
    launch(32'h31, 32'h32, 10'h001, 1'b1);
    wait_req("t5_l_req", 1, 100);
    sw_in = 10'h003;
    wait_done("t5_done", 200);
    chk("t5_cfg_hold", eng_cfg, 10'h001);
    tick(DB_CYC + 8);
    launch(32'h41, 32'h42, 10'h003, 1'b1);
    wait_done("t5b_done", 200);
    chk("t5_cfg_new", eng_cfg, 10'h003);
`ifdef SW_DEBOUNCE_EN
    tick(1);
    sw_in = 10'h007;
    launch(32'h51, 32'h52, 10'h003, 1'b1);
    sw_in = 10'h003;
    wait_done("t5c_done", 200);
    chk("t5_glitch_rejected", eng_cfg, 10'h003);
`endif

    // 6: async reset during RSP_L, then a normal frame
    launch(32'h61, 32'h62, 10'h003, 1'b1);
    wait_req("t6_l_req", 1, 100);
    tick(2);
    #1 reset_n = 1'b0;
    #1;
    chk("t6_out_l", data_l_out, 0);
    chk("t6_out_r", data_r_out, 0);
    chk("t6_busy", busy, 0);
    chk("t6_eng", {eng_valid, eng_data, eng_cfg}, 0);
    chk("t6_done_flags", {frame_done, overrun, timeout_err}, 0);
    req_q.delete(); frm_q.delete();
    exp_l = '0; exp_r = '0;
    tick(3);
    reset_n = 1'b1;
    lat = 3;
    set_sw(10'h003);
    launch(32'h71, 32'h72, 10'h003, 1'b1);
    wait_done("t6_post_done", 200);
    chk("t6_post_l", data_l_out, 32'h72);
    chk("t6_post_r", data_r_out, 32'h73);

    // Randomised frames
    for (int i = 0; i < 20; i++) begin
      sv = NCFG'($urandom_range(0, (1 << NCFG) - 1));
      set_sw(sv);
      lat = $urandom_range(1, 6);
      ready_delay = $urandom_range(0, 3);
      mute = ($urandom_range(0, 7) == 0);
      launch($urandom, $urandom, sv, 1'b1);
      wait_done("rand_done", 400);
    end
    mute = 1'b0;
    tick(10);
    chk("req_q_drained", req_q.size(), 0);
    chk("frm_q_drained", frm_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
